mmio_responder: RTL and testbench



---
 rtl/mmio_responder.sv | 166 ++++++++++++++++
 tb/tb_mmio_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_responder.sv
// mmio_responder: I/O-region load/store responder with UART RX/TX FIFOs and
// cycle / retired-instruction counters. Load data is returned one cycle late.
module mmio_responder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    input  logic        inst_retired,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT  = (PW+1)'(FIFO_DEPTH);
    localparam logic [31:0] A_STATUS  = 32'h8000_0000;
    localparam logic [31:0] A_RX      = 32'h8000_0004;
    localparam logic [31:0] A_TX      = 32'h8000_0008;
    localparam logic [31:0] A_CYCLE   = 32'h8000_0010;
    localparam logic [31:0] A_INSTRET = 32'h8000_0014;
    localparam logic [31:0] A_CTR_RST = 32'h8000_0018;

    logic [7:0]  rx_mem_q [FIFO_DEPTH];
    logic [7:0]  tx_mem_q [FIFO_DEPTH];
    logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [PW:0]   rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic          rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
    logic [31:0]   cyc_q, cyc_d, ins_q, ins_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   read_val_s;

    logic store_s, load_s;
    logic rx_full_s, rx_nempty_s, tx_full_s, tx_nempty_s;
    logic rx_push_s, rx_pop_s, tx_push_req_s, tx_push_s, tx_pop_s;
    logic ctr_clr_s, sticky_clr_s;
    logic unused_s;

    // A simultaneous load+store is a store; full/empty use pre-edge occupancy.
    assign store_s       = we;
    assign load_s        = re & ~we;
    assign rx_full_s     = (rx_cnt_q == FULL_CNT);
    assign tx_full_s     = (tx_cnt_q == FULL_CNT);
    assign rx_nempty_s   = (rx_cnt_q != {(PW+1){1'b0}});
    assign tx_nempty_s   = (tx_cnt_q != {(PW+1){1'b0}});
    assign rx_push_s     = rx_valid & ~rx_full_s;
    assign rx_pop_s      = load_s & (addr == A_RX) & rx_nempty_s;
    assign tx_push_req_s = store_s & (addr == A_TX) & wmask[0];
    assign tx_push_s     = tx_push_req_s & ~tx_full_s;
    assign tx_pop_s      = tx_nempty_s & tx_ready;
    assign ctr_clr_s     = store_s & (addr == A_CTR_RST);
    assign sticky_clr_s  = store_s & (addr == A_STATUS);
    assign unused_s      = ^{wdata[31:8], wmask[3:1]};

    assign rdata    = rdata_q;
    assign tx_valid = tx_nempty_s;
    assign tx_data  = tx_nempty_s ? tx_mem_q[tx_rd_q] : 8'h00;

    // Register read mux; unmapped I/O addresses read zero.
    always_comb begin
        read_val_s = 32'h0000_0000;
        case (addr)
            A_STATUS:  read_val_s = {28'h000_0000, tx_ovf_q, rx_ovf_q, rx_nempty_s, ~tx_full_s};
            A_RX:      read_val_s = rx_nempty_s ? {24'h00_0000, rx_mem_q[rx_rd_q]} : 32'h0000_0000;
            A_CYCLE:   read_val_s = cyc_q;
            A_INSTRET: read_val_s = ins_q;
            default:   read_val_s = 32'h0000_0000;
        endcase
    end

    // Next-state for FIFO pointers/counts, sticky flags, counters and rdata.
    always_comb begin
        rx_wr_d = rx_push_s ? rx_wr_q + 1'b1 : rx_wr_q;
        rx_rd_d = rx_pop_s  ? rx_rd_q + 1'b1 : rx_rd_q;
        tx_wr_d = tx_push_s ? tx_wr_q + 1'b1 : tx_wr_q;
        tx_rd_d = tx_pop_s  ? tx_rd_q + 1'b1 : tx_rd_q;
        case ({rx_push_s, rx_pop_s})
            2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
            2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
            default: rx_cnt_d = rx_cnt_q;
        endcase
        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
            2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
            default: tx_cnt_d = tx_cnt_q;
        endcase
        // A new overflow in the clearing cycle keeps the flag set.
        if (rx_valid & rx_full_s) begin
            rx_ovf_d = 1'b1;
        end else if (sticky_clr_s) begin
            rx_ovf_d = 1'b0;
        end else begin
            rx_ovf_d = rx_ovf_q;
        end
        if (tx_push_req_s & tx_full_s) begin
            tx_ovf_d = 1'b1;
        end else if (sticky_clr_s) begin
            tx_ovf_d = 1'b0;
        end else begin
            tx_ovf_d = tx_ovf_q;
        end
        cyc_d = ctr_clr_s ? 32'h0000_0000 : cyc_q + 32'd1;
        ins_d = ctr_clr_s ? 32'h0000_0000 : ins_q + {31'd0, inst_retired};
        if (store_s) begin
            rdata_d = 32'h0000_0000;
        end else if (load_s) begin
            rdata_d = read_val_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // RX FIFO storage and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) rx_mem_q[i] <= 8'h00;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (rx_push_s) rx_mem_q[rx_wr_q] <= rx_data;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end

    // TX FIFO storage and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) tx_mem_q[i] <= 8'h00;
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (tx_push_s) tx_mem_q[tx_wr_q] <= wdata[7:0];
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            tx_cnt_q <= tx_cnt_d;
        end
    end

    // Sticky overflow flags, counters and registered load data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ovf_q <= 1'b0;
            tx_ovf_q <= 1'b0;
            cyc_q    <= 32'h0000_0000;
            ins_q    <= 32'h0000_0000;
            rdata_q  <= 32'h0000_0000;
        end else begin
            rx_ovf_q <= rx_ovf_d;
            tx_ovf_q <= tx_ovf_d;
            cyc_q    <= cyc_d;
            ins_q    <= ins_d;
            rdata_q  <= rdata_d;
        end
    end
endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: directed test-plan steps followed
// by a random phase, all checked against a queue-based reference model.
module tb_mmio_responder;
    localparam int          D         = 4;
    localparam logic [31:0] A_STATUS  = 32'h8000_0000;
    localparam logic [31:0] A_RX      = 32'h8000_0004;
    localparam logic [31:0] A_TX      = 32'h8000_0008;
    localparam logic [31:0] A_CYCLE   = 32'h8000_0010;
    localparam logic [31:0] A_INSTRET = 32'h8000_0014;
    localparam logic [31:0] A_CTR_RST = 32'h8000_0018;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [3:0]  wmask = 4'h0;
    logic        we = 1'b0, re = 1'b0, inst_retired = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0, tx_ready = 1'b0;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic [31:0] cyc_m, ins_m, rdata_m;
    logic        rxo_m, txo_m;
    logic [31:0] amap [8];

    mmio_responder #(.FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wmask(wmask),
        .we(we), .re(re), .rdata(rdata), .inst_retired(inst_retired),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rxq.delete();
        txq.delete();
        cyc_m = 32'd0; ins_m = 32'd0; rdata_m = 32'd0;
        rxo_m = 1'b0; txo_m = 1'b0;
    endtask

    // Advance one clock, update the model from the sampled inputs, compare outputs.
    task automatic tick();
        int          rxn = rxq.size();
        int          txn = txq.size();
        logic        st  = we;
        logic        ld  = re && !we;
        logic [31:0] rv  = 32'd0;
        if (addr == A_STATUS)
            rv = {28'd0, txo_m, rxo_m, (rxn > 0) ? 1'b1 : 1'b0, (txn < D) ? 1'b1 : 1'b0};
        else if (addr == A_RX)
            rv = (rxn > 0) ? {24'd0, rxq[0]} : 32'd0;
        else if (addr == A_CYCLE)
            rv = cyc_m;
        else if (addr == A_INSTRET)
            rv = ins_m;
        @(posedge clk);
        #1;
        if (ld && addr == A_RX && rxn > 0) void'(rxq.pop_front());
        if (txn > 0 && tx_ready) void'(txq.pop_front());
        if (st && addr == A_STATUS) begin rxo_m = 1'b0; txo_m = 1'b0; end
        if (rx_valid) begin
            if (rxn == D) rxo_m = 1'b1;
            else rxq.push_back(rx_data);
        end
        if (st && addr == A_TX && wmask[0]) begin
            if (txn == D) txo_m = 1'b1;
            else txq.push_back(wdata[7:0]);
        end
        if (st && addr == A_CTR_RST) begin
            cyc_m = 32'd0; ins_m = 32'd0;
        end else begin
            cyc_m = cyc_m + 32'd1;
            ins_m = ins_m + {31'd0, inst_retired};
        end
        if (st) rdata_m = 32'd0;
        else if (ld) rdata_m = rv;
        chk("rdata", rdata, rdata_m);
        chk("tx_valid", {31'd0, tx_valid}, {31'd0, (txq.size() > 0) ? 1'b1 : 1'b0});
        chk("tx_data", {24'd0, tx_data}, {24'd0, (txq.size() > 0) ? txq[0] : 8'h00});
    endtask

    task automatic idle();
        we = 1'b0; re = 1'b0; rx_valid = 1'b0; inst_retired = 1'b0; wmask = 4'h0;
    endtask

    task automatic do_load(input logic [31:0] a);
        addr = a; re = 1'b1; tick(); idle();
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        addr = a; wdata = d; wmask = m; we = 1'b1; tick(); idle();
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1; tick(); idle();
    endtask

    initial begin
        amap[0] = A_STATUS; amap[1] = A_RX; amap[2] = A_TX; amap[3] = 32'h8000_000C;
        amap[4] = A_CYCLE; amap[5] = A_INSTRET; amap[6] = A_CTR_RST; amap[7] = 32'h8000_0001;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        rst = 1'b0;

        // Counters
        repeat (10) tick();
        do_load(A_CYCLE);
        chk("cycle_at_10", rdata, 32'd10);
        repeat (3) begin inst_retired = 1'b1; tick(); idle(); end
        do_load(A_INSTRET);
        chk("instret_3", rdata, 32'd3);

        // TX fill and overflow
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_store(A_TX, 32'h0000_0041 + i, 4'h1);
        do_load(A_STATUS);
        chk("tx_full_status0", {31'd0, rdata[0]}, 32'd0);
        do_store(A_TX, 32'h0000_0045, 4'hF);
        do_load(A_STATUS);
        chk("tx_ovf_status3", {31'd0, rdata[3]}, 32'd1);
        do_store(A_TX, 32'h0000_0099, 4'hE);
        chk("tx_head_41", {24'd0, tx_data}, 32'h41);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("tx_drain_order", {24'd0, tx_data}, 32'h41 + i);
            tick();
        end
        chk("tx_valid_fall", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        // RX basic
        do_store(A_STATUS, 32'd0, 4'h0);
        rx_pulse(8'h10);
        rx_pulse(8'h20);
        do_load(A_STATUS);
        chk("rx_status_3", rdata, 32'h3);
        do_load(A_RX); chk("rx_rd_10", rdata, 32'h10);
        do_load(A_RX); chk("rx_rd_20", rdata, 32'h20);
        do_load(A_RX); chk("rx_rd_empty", rdata, 32'h0);
        do_load(A_STATUS);
        chk("rx_status_empty", rdata, 32'h1);

        // RX overflow with simultaneous pop
        for (int i = 0; i < 4; i++) rx_pulse(8'hA0 + 8'(i));
        rx_data = 8'hA4; rx_valid = 1'b1; addr = A_RX; re = 1'b1; tick(); idle();
        chk("rx_ovf_pop_oldest", rdata, 32'hA0);
        do_load(A_STATUS);
        chk("rx_ovf_status", rdata, 32'h7);
        do_store(A_STATUS, 32'hFFFF_FFFF, 4'hF);
        do_load(A_STATUS);
        chk("rx_ovf_cleared", rdata, 32'h3);
        for (int i = 1; i < 4; i++) begin
            do_load(A_RX);
            chk("rx_ovf_drain", rdata, 32'hA0 + i);
        end

        // Counter reset vs increment
        addr = A_CTR_RST; we = 1'b1; inst_retired = 1'b1; tick(); idle();
        do_load(A_CYCLE);   chk("ctr_rst_cycle0", rdata, 32'd0);
        do_load(A_CYCLE);   chk("ctr_rst_cycle1", rdata, 32'd1);
        do_load(A_INSTRET); chk("ctr_rst_instret0", rdata, 32'd0);

        // Reset mid-drain
        do_store(A_TX, 32'h0000_0051, 4'h1);
        do_store(A_TX, 32'h0000_0052, 4'h1);
        do_load(A_CYCLE);
        tx_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("post_rst_empty", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        // Random phase
        for (int n = 0; n < 400; n++) begin
            addr  = amap[$urandom_range(7)];
            wdata = $urandom;
            wmask = 4'($urandom_range(15));
            we    = ($urandom_range(99) < 30);
            re    = ($urandom_range(99) < 40);
            if (addr == A_CTR_RST && $urandom_range(3) != 0) we = 1'b0;
            rx_valid     = ($urandom_range(99) < 35);
            rx_data      = 8'($urandom);
            tx_ready     = ($urandom_range(99) < 40);
            inst_retired = $urandom_range(1);
            tick();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
